// File: rtl/door_ctrl_pkg.sv
// rtl/door_ctrl_pkg.sv - shared state encodings, direction constants and timer sizing for the door sequencer
package door_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLOSED  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_OPENING = 3'd3,
    ST_CLOSING = 3'd4,
    ST_DEAD    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  // One counter serves travel, dead and hold phases, so it is sized for the longest.
  function automatic int timer_width(input int travel_max, input int dead_cyc, input int hold_cyc);
    int m;
    m = travel_max;
    if (dead_cyc > m) m = dead_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/door_timer.sv
// rtl/door_timer.sv - shared phase up-counter with synchronous clear and terminal compare
module door_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic         term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term = (count_q == term_val);

endmodule

// File: rtl/door_motion_sequencer.sv
// rtl/door_motion_sequencer.sv - garage door motion FSM with request arbitration and safety sequencing
// Optional auto-close from OPEN is compiled in when AUTO_CLOSE_EN is defined.
module door_motion_sequencer
  import door_ctrl_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int DEAD_CYC   = 8,
  parameter int TRAVEL_MAX = 1000,
  parameter int HOLD_CYC   = 5000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic            UP_Max,
  input  logic            DN_Max,
  input  logic            OBST,
  output logic [NREQ-1:0] GNT,
  output logic            UP_M,
  output logic            DN_M,
  output logic [2:0]      STATE,
  output logic            FAULT
);

  localparam int TW = timer_width(TRAVEL_MAX, DEAD_CYC, HOLD_CYC);
  localparam logic [TW-1:0] TRAVEL_TERM = TW'(TRAVEL_MAX - 1);
  localparam logic [TW-1:0] DEAD_TERM   = TW'(DEAD_CYC - 1);
`ifdef AUTO_CLOSE_EN
  localparam logic [TW-1:0] HOLD_TERM   = TW'(HOLD_CYC - 1);
`endif

  state_t          state_q;
  state_t          state_d;
  dir_t            last_dir_q;
  dir_t            last_dir_d;
  logic [NREQ-1:0] req_low;
  logic            grant;
  logic            conflict;
  logic            timer_clr;
  logic            timer_en;
  logic            timer_term;
  logic [TW-1:0]   timer_term_val;

  // Lowest set bit wins; requests are held off entirely during the reversal dead time.
  assign req_low  = REQ & (~REQ + NREQ'(1));
  assign GNT      = (state_q == ST_DEAD) ? '0 : req_low;
  assign grant    = |GNT;
  assign conflict = UP_Max & DN_Max;

  always_comb begin
    state_d = state_q;
    if (conflict && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            if (DN_Max) begin
              state_d = ST_OPENING;
            end else if (UP_Max) begin
              state_d = ST_CLOSING;
            end else begin
              state_d = (last_dir_q == DIR_UP) ? ST_CLOSING : ST_OPENING;
            end
          end
        end
        ST_CLOSED: begin
          if (grant) state_d = ST_OPENING;
        end
        ST_OPEN: begin
          if (grant && !OBST) state_d = ST_CLOSING;
`ifdef AUTO_CLOSE_EN
          if (timer_term && !OBST) state_d = ST_CLOSING;
`endif
        end
        ST_OPENING: begin
          if (timer_term) begin
            state_d = ST_FAULT;
          end else if (UP_Max) begin
            state_d = ST_OPEN;
          end else if (grant) begin
            state_d = ST_IDLE;
          end
        end
        ST_CLOSING: begin
          if (timer_term) begin
            state_d = ST_FAULT;
          end else if (DN_Max) begin
            state_d = ST_CLOSED;
          end else if (OBST) begin
            state_d = ST_DEAD;
          end else if (grant) begin
            state_d = ST_IDLE;
          end
        end
        ST_DEAD: begin
          if (timer_term) state_d = ST_OPENING;
        end
        ST_FAULT: begin
          if (grant) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    last_dir_d = last_dir_q;
    if (state_d == ST_OPENING) begin
      last_dir_d = DIR_UP;
    end else if (state_d == ST_CLOSING) begin
      last_dir_d = DIR_DN;
    end
  end

  // Every phase starts from zero; in OPEN a broken beam restarts the hold period.
  always_comb begin
    timer_clr      = (state_d != state_q) || ((state_q == ST_OPEN) && OBST);
    timer_en       = 1'b0;
    timer_term_val = TRAVEL_TERM;
    case (state_q)
      ST_OPENING, ST_CLOSING: timer_en = 1'b1;
      ST_DEAD: begin
        timer_en       = 1'b1;
        timer_term_val = DEAD_TERM;
      end
`ifdef AUTO_CLOSE_EN
      ST_OPEN: begin
        timer_en       = 1'b1;
        timer_term_val = HOLD_TERM;
      end
`endif
      default: timer_en = 1'b0;
    endcase
  end

  door_timer #(
    .W(TW)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (timer_clr),
    .en      (timer_en),
    .term_val(timer_term_val),
    .term    (timer_term)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_DN;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign UP_M  = (state_q == ST_OPENING);
  assign DN_M  = (state_q == ST_CLOSING);
  assign STATE = state_q;
  assign FAULT = (state_q == ST_FAULT);

endmodule

// File: doc/door_motion_sequencer.md
# door_motion_sequencer

Top-level motion sequencer for the garage door motor: arbitrates open/close/stop requests from several sources (wall button, remote, keypad) with fixed priority and drives the UP/DN motor enables. Adds safety and convenience sequencing around the bare motor drive:
- reverse on obstruction, with a dead time before reversing;
- travel-timeout fault;
- limit-switch conflict detection;
- optional auto-close.

It sits between the request/sensor conditioning logic and the motor driver pins.

## Interface
- NREQ, 3 — number of requesters; bit 0 has highest priority
- DEAD_CYC, 8 — motor-off cycles before an obstruction reversal, ≥1
- TRAVEL_MAX, 1000 — maximum cycles in OPENING or CLOSING before FAULT, ≥2
- HOLD_CYC, 5000 — cycles spent in OPEN before auto-close, ≥1

- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- REQ  in  NREQ  request lines; held high until granted
- UP_Max  in  1  upper limit switch, 1 = fully open
- DN_Max  in  1  lower limit switch, 1 = fully closed
- OBST  in  1  obstruction beam broken
- GNT  out  NREQ  one-hot grant, combinational
- UP_M  out  1  motor up enable
- DN_M  out  1  motor down enable
- STATE  out  3  current state encoding
- FAULT  out  1  high while in FAULT

## Operation
- States and encodings: IDLE=0, CLOSED=1, OPEN=2, OPENING=3, CLOSING=4, DEAD=5, FAULT=6.
- Reset: state is IDLE, last_dir=down, timer=0; UP_M, DN_M and FAULT are 0, STATE=0.
- Moore outputs decoded from registered state:
  - UP_M=1 only in OPENING.
  - DN_M=1 only in CLOSING.
  - UP_M and DN_M are never both 1.
- Grant rules:
  - GNT is the lowest-index set REQ bit.
  - GNT is asserted only in IDLE, CLOSED, OPEN, OPENING, CLOSING and FAULT. In DEAD, GNT=0 and requests wait.
  - A requester must drop REQ after the edge at which it saw GNT; if REQ stays high, the block re-grants and acts on the new state.
- Transition priority when several conditions hold in the same cycle: limit conflict > travel timeout > limit reached > OBST > grant.
- Transitions from any state except FAULT:
  - UP_Max & DN_Max → FAULT.
- IDLE, on grant:
  - DN_Max → OPENING.
  - else UP_Max → CLOSING.
  - else (door mid-travel) → opposite of last_dir.
- CLOSED, on grant → OPENING.
- OPEN:
  - grant with OBST=0 → CLOSING.
  - grant with OBST=1 is consumed; state stays OPEN.
- OPENING:
  - UP_Max → OPEN.
  - grant → IDLE (stop).
  - timeout → FAULT.
  - On entry, last_dir is set to up.
- CLOSING:
  - DN_Max → CLOSED.
  - OBST → DEAD.
  - grant → IDLE.
  - timeout → FAULT.
  - On entry, last_dir is set to down.
- DEAD: motor off for DEAD_CYC cycles, then → OPENING.
- FAULT: motor off; a grant → IDLE. This is the only exit other than RST.

## Timing
- REQ sampled at edge k with GNT high: the new state, and therefore the new UP_M/DN_M, is visible after edge k. Latency is 1 cycle.
- Limit, OBST and timeout effects likewise take 1 cycle.
- Travel: the timer loads 0 on entry to OPENING/CLOSING and increments each cycle. The transition to FAULT happens at the edge where timer==TRAVEL_MAX-1, so motion lasts at most TRAVEL_MAX cycles.
- DEAD: the timer loads 0 on entry. At the edge where timer==DEAD_CYC-1 the state goes to OPENING. UP_M is high from the DEAD_CYC+1-th cycle after OBST was sampled.
- Auto-close: the timer counts in OPEN while OBST=0 and clears to 0 on any cycle with OBST=1. At timer==HOLD_CYC-1 the state goes to CLOSING.
- RST asserted mid-motion: UP_M/DN_M drop asynchronously and the block returns to IDLE. last_dir resets, so the first grant from mid-travel opens the door.

## Configuration
- AUTO_CLOSE_EN defined: the OPEN-state hold timer and automatic close are compiled in as described above.
- Not defined: OPEN leaves only on a grant or a limit conflict, and HOLD_CYC is unused. All other behaviour is identical.

## Structure
- Shared package door_ctrl_pkg holds the 3-bit state typedef/encodings and the direction constants.
- Sub-module door_timer: a single up-counter with synchronous clear and terminal-compare input, shared by the travel, dead and hold phases (these are mutually exclusive). Width is $clog2 of the largest of TRAVEL_MAX, DEAD_CYC and HOLD_CYC.
- The fixed-priority grant is inline combinational logic.

## Test plan
- Open and close cycle:
  - Stimulus: reset, DN_Max=1, REQ=3'b001 for one cycle.
  - Response: GNT=001, then STATE=3 and UP_M=1 on the next cycle.
  - Stimulus: raise UP_Max.
  - Response: STATE=2, UP_M=0.
- Arbitration and stop:
  - Stimulus: REQ=3'b110 in CLOSED.
  - Response: GNT=010, then OPENING.
  - Stimulus: REQ=3'b100 mid-travel.
  - Response: GNT=100, then IDLE with both motors 0.
  - Stimulus: another grant.
  - Response: CLOSING (last_dir was up).
- Obstruction reversal:
  - Stimulus: OBST=1 during CLOSING.
  - Response: DN_M=0 next cycle, STATE=5 for 8 cycles, then UP_M=1. REQ pulsed during DEAD gets GNT=000.
- Travel timeout:
  - Stimulus: OPENING with UP_Max held 0, TRAVEL_MAX=10.
  - Response: UP_M high exactly 10 cycles, then FAULT=1, STATE=6.
  - Stimulus: REQ.
  - Response: IDLE.
- Limit conflict:
  - Stimulus: UP_Max=DN_Max=1 together with REQ in CLOSED.
  - Response: FAULT, not OPENING.
- Auto-close with AUTO_CLOSE_EN, HOLD_CYC=20:
  - Stimulus: OPEN with OBST pulsed at cycle 10.
  - Response: CLOSING starts 20 cycles after OBST falls.
  - Without the macro: the door stays OPEN for more than 100 cycles.
